rr_arbiter_8: RTL and testbench

//  Round-robin arbiter that shares one decoded resource between 8 requesters
//  (e.g. the 8 select lines of a 3-to-8 decode). It picks one requester, holds
//  the grant until release, then rotates priority. The registered 3-bit grant

---
 rtl/rr_arbiter_8.sv | 101 ++++++++++
 tb/tb_rr_arbiter_8.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters; forced release on hold timeout when RR_ARB_TIMEOUT_EN is defined.
// Latency: req to grant 1 cycle; release to next grant always passes one IDLE cycle.
// Backpressure: holder keeps the grant until done, req drop or (optionally) timeout.
module rr_arbiter_8 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state;
  logic [2:0]       ptr;
  logic [CNT_W-1:0] hold_cnt;
  logic             timeout_hit;
  logic             release_cond;
  logic [2:0]       pick_idx;

  if ((2 ** CNT_W) <= MAX_HOLD || MAX_HOLD < 1) begin : g_cnt_w_check
    $error("rr_arbiter_8: CNT_W too narrow for MAX_HOLD");
  end

  // First set request in the order ptr, ptr+1, ... wrapping mod 8.
  function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [2:0] pick;
    logic [2:0] idx;
    logic       found;
    pick  = p;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      idx = p + 3'(k);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign pick_idx = rr_pick(req, ptr);

`ifdef RR_ARB_TIMEOUT_EN
  assign timeout_hit = (hold_cnt == CNT_W'(MAX_HOLD - 1)) && !done;
`else
  assign timeout_hit = 1'b0;
`endif

  assign release_cond = done | ~req[gnt_idx] | timeout_hit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt_idx   <= 3'd0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
      ptr       <= 3'd0;
      hold_cnt  <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            gnt_idx   <= pick_idx;
            gnt_valid <= 1'b1;
            hold_cnt  <= '0;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (release_cond) begin
            gnt_valid <= 1'b0;
            ptr       <= gnt_idx + 3'd1;
            timeout   <= timeout_hit;
            state     <= IDLE;
          end else if (hold_cnt != '1) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // One-hot view of the registered index; never more than one bit set.
  always_comb begin
    gnt = 8'h00;
    if (gnt_valid) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed bench for rr_arbiter_8; built with MAX_HOLD=4 so the timeout path is short.
module tb_rr_arbiter_8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rr_arbiter_8 #(.MAX_HOLD(4), .CNT_W(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .done     (done),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_valid(gnt_valid),
    .timeout  (timeout)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Compares {gnt, gnt_idx, gnt_valid, timeout} against the hand-computed values.
  task automatic chk(input string tag, input logic [7:0] e_gnt, input logic [2:0] e_idx,
                     input logic e_vld, input logic e_to);
    logic [12:0] obs;
    logic [12:0] exp;
    obs = {gnt, gnt_idx, gnt_valid, timeout};
    exp = {e_gnt, e_idx, e_vld, e_to};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed gnt=%h idx=%0d vld=%b to=%b expected gnt=%h idx=%0d vld=%b to=%b",
             tag, obs[12:5], obs[4:2], obs[1], obs[0], exp[12:5], exp[4:2], exp[1], exp[0]);
    end
  endtask

  initial begin
    logic [7:0] oh;
    rst_n = 1'b0;
    req   = 8'hFF;
    done  = 1'b0;

    // Reset held for 3 cycles with all requests up
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_hold", 8'h00, 3'd0, 1'b0, 1'b0);
    end

    // Single requester 2, then release via done
    rst_n = 1'b1;
    req   = 8'h04;
    tick();
    chk("grant_idx2", 8'h04, 3'd2, 1'b1, 1'b0);
    done = 1'b1;
    tick();
    chk("release_idx2", 8'h00, 3'd2, 1'b0, 1'b0);
    done = 1'b0;

    // ptr=3: req 0 and 2 -> wrap to 0, then 2
    req = 8'h05;
    tick();
    chk("wrap_idx0", 8'h01, 3'd0, 1'b1, 1'b0);
    done = 1'b1;
    tick();
    chk("release_idx0", 8'h00, 3'd0, 1'b0, 1'b0);
    done = 1'b0;
    tick();
    chk("then_idx2", 8'h04, 3'd2, 1'b1, 1'b0);

    // Dropping the holder's request releases it
    req = 8'h00;
    tick();
    chk("req_drop", 8'h00, 3'd2, 1'b0, 1'b0);
    tick();
    chk("idle_no_req", 8'h00, 3'd2, 1'b0, 1'b0);

    // Full rotation from reset with all requesters active
    rst_n = 1'b0;
    tick();
    chk("reset_again", 8'h00, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    req   = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      oh = 8'h01 << (k % 8);
      tick();
      chk("rr_grant", oh, 3'(k % 8), 1'b1, 1'b0);
      tick();
      chk("rr_hold", oh, 3'(k % 8), 1'b1, 1'b0);
      done = 1'b1;
      tick();
      chk("rr_gap", 8'h00, 3'(k % 8), 1'b0, 1'b0);
      done = 1'b0;
    end

    // ptr=1: grant 5, other req changes ignored, then drop req[5]
    req = 8'h20;
    tick();
    chk("grant_idx5", 8'h20, 3'd5, 1'b1, 1'b0);
    req = 8'hE0;
    tick();
    chk("others_ignored", 8'h20, 3'd5, 1'b1, 1'b0);
    req = 8'hC0;
    tick();
    chk("drop_req5", 8'h00, 3'd5, 1'b0, 1'b0);

    // Regrant 5 (ptr=6 -> search 6 first only if req[6]; here only 5), then reset mid-grant
    req = 8'h20;
    tick();
    chk("regrant_idx5", 8'h20, 3'd5, 1'b1, 1'b0);
    rst_n = 1'b0;
    tick();
    chk("reset_mid_grant", 8'h00, 3'd0, 1'b0, 1'b0);
    // ptr back to 0: with req 5 and 6, 5 wins (ptr=6 would have picked 6)
    rst_n = 1'b1;
    req   = 8'h60;
    tick();
    chk("ptr_reset_pick5", 8'h20, 3'd5, 1'b1, 1'b0);

    // Hold with done=0 and a single persistent requester
    rst_n = 1'b0;
    req   = 8'h01;
    tick();
    chk("reset_before_hold", 8'h00, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("hold_window", 8'h01, 3'd0, 1'b1, 1'b0);
    end
`ifdef RR_ARB_TIMEOUT_EN
    tick();
    chk("timeout_pulse", 8'h00, 3'd0, 1'b0, 1'b1);
    tick();
    chk("regrant_after_timeout", 8'h01, 3'd0, 1'b1, 1'b0);
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("no_timeout_hold", 8'h01, 3'd0, 1'b1, 1'b0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
